// File: rtl/bus_pkg.sv
// Shared processor-bus definitions used by the L1 cache and the memory responder.
// Holds default bus widths, request tag field positions, request type codes,
// block geometry and the responder state encoding.
package bus_pkg;

    localparam int unsigned DEF_BUS_DATA_WIDTH = 64;
    localparam int unsigned DEF_BUS_TAG_WIDTH  = 13;

    // Request tag layout: [12] write, [11:8] type, [7:0] initiator id
    localparam int unsigned TAG_WRITE_BIT = 12;
    localparam int unsigned TAG_TYPE_MSB  = 11;
    localparam int unsigned TAG_TYPE_LSB  = 8;

    localparam logic [3:0] TYPE_MEMORY = 4'h1;

    // A 64-byte block is eight 64-bit beats
    localparam int unsigned BEATS_PER_BLOCK = 8;
    localparam int unsigned BEAT_IDX_W      = 3;

    // Responder states
    typedef logic [2:0] resp_state_t;
    localparam resp_state_t ST_IDLE      = 3'd0;
    localparam resp_state_t ST_WR_DATA   = 3'd1;
    localparam resp_state_t ST_RD_WAIT   = 3'd2;
    localparam resp_state_t ST_RD_FIRST  = 3'd3;
    localparam resp_state_t ST_RD_STREAM = 3'd4;

endpackage

// File: rtl/mem_array.sv
// Word-addressed backing store: one write port, one synchronous read port.
// Ports:
//   clk, reset      clock, synchronous active-low reset (read register only)
//   we/waddr/wdata  write port, written on the clock edge when we=1
//   re/raddr        read request; rdata updates on the edge when re=1
//   rdata           registered read data, holds its value while re=0
module mem_array #(
    parameter int unsigned WORDS = 4096,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(WORDS)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [WORDS];

    // Storage is never cleared by reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register doubles as the responder's registered data output
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bus_memory_responder.sv
// Memory-side endpoint of the processor bus. Accepts block read/write
// requests, stores 64-byte blocks in a local array and returns reads as
// 8-beat bursts.
// Ports:
//   clk, reset     clock, synchronous active-low reset
//   bus_reqcyc     request valid, held until acked
//   bus_req        byte address on the address beat, write data on data beats
//   bus_reqtag     request tag: write bit, type, initiator id
//   bus_reqack     one-cycle accept pulse
//   bus_respcyc    response beat valid
//   bus_resp       response data beat
//   bus_resptag    tag of the request being answered
//   bus_respack    initiator accepts the first beat of the burst
module bus_memory_responder
    import bus_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = DEF_BUS_DATA_WIDTH,
    parameter int unsigned BUS_TAG_WIDTH  = DEF_BUS_TAG_WIDTH,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int unsigned ADDR_W = $clog2(MEM_WORDS);
    localparam int unsigned BLK_W  = ADDR_W - BEAT_IDX_W;
    localparam int unsigned LAT_W  = 4;
    // Byte address bit holding the block index LSB (8-byte words, 8 words/block)
    localparam int unsigned BLK_LSB = BEAT_IDX_W + 3;

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS_PER_BLOCK - 1);
    localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(READ_LATENCY - 1);

    resp_state_t              state, state_nxt;
    logic [BLK_W-1:0]         blk, blk_nxt;
    logic [BUS_TAG_WIDTH-1:0] tag, tag_nxt;
    logic [BEAT_IDX_W-1:0]    beat, beat_nxt;
    logic [LAT_W-1:0]         lat_cnt, lat_cnt_nxt;
    logic                     reqack_nxt;
    logic                     respcyc_nxt;
    logic [BUS_TAG_WIDTH-1:0] resptag_nxt;
    logic                     accept;
    logic                     is_mem;
    logic                     mem_we;
    logic                     mem_re;
    logic [BEAT_IDX_W-1:0]    rd_beat;

    assign is_mem = (tag[TAG_TYPE_MSB:TAG_TYPE_LSB] == TYPE_MEMORY);

    // Next-state, counters and memory port control
    always_comb begin
        state_nxt   = state;
        blk_nxt     = blk;
        tag_nxt     = tag;
        beat_nxt    = beat;
        lat_cnt_nxt = lat_cnt;
        accept      = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        rd_beat     = beat;

        case (state)
            ST_IDLE: begin
                accept = bus_reqcyc;
            end
            ST_WR_DATA: begin
                // The ack cycle carries no data; beats follow it
                if (!bus_reqack) begin
                    mem_we   = is_mem;
                    beat_nxt = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (!is_mem) begin
                    state_nxt = ST_IDLE;
                end else if (lat_cnt == LAT_LAST) begin
                    // Fetch beat 0 so it lands in the output register with RD_FIRST
                    state_nxt   = ST_RD_FIRST;
                    lat_cnt_nxt = '0;
                    mem_re      = 1'b1;
                    rd_beat     = '0;
                end else begin
                    lat_cnt_nxt = lat_cnt + 1'b1;
                end
            end
            ST_RD_FIRST: begin
                // Beat 0 stays in the read register until the initiator acks
                if (bus_respack) begin
                    state_nxt = ST_RD_STREAM;
                    beat_nxt  = BEAT_IDX_W'(1);
                    mem_re    = 1'b1;
                    rd_beat   = BEAT_IDX_W'(1);
                end
            end
            ST_RD_STREAM: begin
                if (beat == LAST_BEAT) begin
                    // Final beat: a waiting request is accepted on this edge
                    state_nxt = ST_IDLE;
                    beat_nxt  = '0;
                    accept    = bus_reqcyc;
                end else begin
                    beat_nxt = beat + 1'b1;
                    mem_re   = 1'b1;
                    rd_beat  = beat + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        reqack_nxt = accept;
        if (accept) begin
            blk_nxt     = bus_req[ADDR_W+2:BLK_LSB];
            tag_nxt     = bus_reqtag;
            beat_nxt    = '0;
            lat_cnt_nxt = '0;
            state_nxt   = bus_reqtag[TAG_WRITE_BIT] ? ST_WR_DATA : ST_RD_WAIT;
        end

        respcyc_nxt = (state_nxt == ST_RD_FIRST) || (state_nxt == ST_RD_STREAM);
        resptag_nxt = respcyc_nxt ? tag_nxt : '0;
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            blk         <= '0;
            tag         <= '0;
            beat        <= '0;
            lat_cnt     <= '0;
            bus_reqack  <= 1'b0;
            bus_respcyc <= 1'b0;
            bus_resptag <= '0;
        end else begin
            state       <= state_nxt;
            blk         <= blk_nxt;
            tag         <= tag_nxt;
            beat        <= beat_nxt;
            lat_cnt     <= lat_cnt_nxt;
            bus_reqack  <= reqack_nxt;
            bus_respcyc <= respcyc_nxt;
            bus_resptag <= resptag_nxt;
        end
    end

    // Backing store; its read register drives bus_resp directly
    mem_array #(
        .WORDS (MEM_WORDS),
        .WIDTH (BUS_DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr ({blk, beat}),
        .wdata (bus_req),
        .re    (mem_re),
        .raddr ({blk, rd_beat}),
        .rdata (bus_resp)
    );

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed testbench for bus_memory_responder with READ_LATENCY=4.
module tb_bus_memory_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_memory_responder #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .MEM_WORDS      (4096),
        .READ_LATENCY   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Advance one cycle; outputs are then stable for the new cycle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise a request and wait for its ack; returns in the ack cycle
    task automatic issue(input logic [63:0] addr, input logic [12:0] tg);
        int t = 0;
        bus_reqcyc = 1'b1;
        bus_req    = addr;
        bus_reqtag = tg;
        do begin
            step();
            t++;
        end while (!bus_reqack && t < 40);
        check("ack_latency", 64'(t), 64'(1));
        bus_reqcyc = 1'b0;
        bus_req    = '0;
    endtask

    // Block write with data d0+i on beat i; returns when the responder is idle
    task automatic bus_write(input logic [63:0] addr, input logic [12:0] tg,
                             input logic [63:0] d0, output int resp_seen);
        resp_seen = 0;
        issue(addr, tg);
        for (int i = 0; i < 8; i++) begin
            step();
            bus_req = d0 + 64'(i);
            if (bus_respcyc) resp_seen++;
        end
        step();
        if (bus_respcyc) resp_seen++;
        bus_req = '0;
    endtask

    // Collect a burst starting from the ack cycle; respack after dly beat-0 cycles.
    // Returns in the cycle after the final beat.
    task automatic receive_burst(input int dly, input logic [63:0] e0, input logic [12:0] tg);
        int lat = 0;
        while (!bus_respcyc && lat < 40) begin
            step();
            lat++;
            check("wait_noack", 64'(bus_reqack), 64'(0));
        end
        check("read_latency", 64'(lat), 64'(4));
        check("resptag", 64'(bus_resptag), 64'(tg));
        for (int k = 0; k < dly; k++) begin
            check("beat0_hold", bus_resp, e0);
            check("respcyc_hold", 64'(bus_respcyc), 64'(1));
            step();
        end
        bus_respack = 1'b1;
        check("beat0", bus_resp, e0);
        check("respcyc_beat0", 64'(bus_respcyc), 64'(1));
        step();
        bus_respack = 1'b0;
        for (int i = 1; i < 8; i++) begin
            check("beat", bus_resp, e0 + 64'(i));
            check("respcyc_beat", 64'(bus_respcyc), 64'(1));
            check("busy_noack", 64'(bus_reqack), 64'(0));
            step();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int cnt;
        reset       = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;

        // Reset values
        repeat (3) step();
        check("rst_reqack", 64'(bus_reqack), 64'(0));
        check("rst_respcyc", 64'(bus_respcyc), 64'(0));
        check("rst_resp", bus_resp, 64'(0));
        check("rst_resptag", 64'(bus_resptag), 64'(0));
        reset = 1'b1;

        // Preload blocks 0..2 with word i = 0x1000+i
        for (int b = 0; b < 3; b++) begin
            bus_write(64'(b * 64), 13'h1101, 64'h1000 + 64'(b * 8), seen);
        end

        // Plain read, respack on the first beat
        issue(64'h48, 13'h0105);
        receive_burst(0, 64'h1008, 13'h0105);
        check("end_respcyc", 64'(bus_respcyc), 64'(0));
        check("end_resptag", 64'(bus_resptag), 64'(0));

        // Delayed respack: beat 0 held for 5 cycles
        issue(64'h48, 13'h0105);
        receive_burst(5, 64'h1008, 13'h0105);
        check("dly_end_respcyc", 64'(bus_respcyc), 64'(0));

        // Back-to-back reads with bus_reqcyc held high
        issue(64'h48, 13'h0105);
        bus_reqcyc = 1'b1;
        bus_req    = 64'h88;
        bus_reqtag = 13'h0106;
        receive_burst(0, 64'h1008, 13'h0105);
        check("b2b_ack", 64'(bus_reqack), 64'(1));
        check("b2b_gap_respcyc", 64'(bus_respcyc), 64'(0));
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        receive_burst(0, 64'h1010, 13'h0106);

        // Non-MEMORY read: acked, never answered
        issue(64'h48, 13'h0305);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_respcyc) cnt++;
        end
        check("nonmem_resp", 64'(cnt), 64'(0));

        // Non-MEMORY write: beats consumed, memory untouched
        bus_write(64'h0, 13'h1305, 64'hDEAD_0000, seen);
        issue(64'h0, 13'h0107);
        receive_burst(0, 64'h1000, 13'h0107);

        // Reset during beat 3 of a burst
        issue(64'h48, 13'h0105);
        cnt = 0;
        while (!bus_respcyc && cnt < 40) begin
            step();
            cnt++;
        end
        bus_respack = 1'b1;
        step();
        bus_respack = 1'b0;
        step();
        step();
        check("pre_rst_beat3", bus_resp, 64'h100B);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("midrst_reqack", 64'(bus_reqack), 64'(0));
        check("midrst_respcyc", 64'(bus_respcyc), 64'(0));
        check("midrst_resp", bus_resp, 64'(0));
        check("midrst_resptag", 64'(bus_resptag), 64'(0));
        issue(64'h48, 13'h0105);
        receive_burst(0, 64'h1008, 13'h0105);

        // Write then read the same block through an unaligned address
        bus_write(64'h40, 13'h1105, 64'hA0, seen);
        check("write_no_resp", 64'(seen), 64'(0));
        issue(64'h7F, 13'h0108);
        receive_burst(0, 64'hA0, 13'h0108);
        check("wr_rd_end_respcyc", 64'(bus_respcyc), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
